// File: rtl/ladybird_inst_prefetch_if.sv
// Core instruction port and instruction memory read port of the prefetch buffer.
// slave = the prefetch block, master = the core/memory environment.
interface ladybird_inst_prefetch_if #(
    parameter int unsigned XLEN = 32
);
    logic            c_req;
    logic [XLEN-1:0] c_addr;
    logic            c_gnt;
    logic            c_data_gnt;
    logic [XLEN-1:0] c_data;
    logic            m_req;
    logic [XLEN-1:0] m_addr;
    logic            m_gnt;
    logic            m_valid;
    logic [XLEN-1:0] m_data;

    modport slave (
        input  c_req, c_addr, m_gnt, m_valid, m_data,
        output c_gnt, c_data_gnt, c_data, m_req, m_addr
    );

    modport master (
        output c_req, c_addr, m_gnt, m_valid, m_data,
        input  c_gnt, c_data_gnt, c_data, m_req, m_addr
    );
endinterface

// File: rtl/ladybird_inst_prefetch.sv
// Sequential instruction prefetch buffer: streams PC+4, PC+8, ... into a FIFO, flushes on branch.
// Optional hit/miss counters are enabled by defining LADYBIRD_PREFETCH_STATS_EN.
module ladybird_inst_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     arst,
    ladybird_inst_prefetch_if.slave  bus
`ifdef LADYBIRD_PREFETCH_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);
    localparam int unsigned     PTR_W      = $clog2(DEPTH);
    localparam int unsigned     CNT_W      = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] WORD       = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {C_IDLE, C_CHECK, C_WAIT} c_state_t;

    c_state_t         state_q, state_d;
    logic [XLEN-1:0]  req_addr_q, exp_addr_q, fetch_addr_q;
    logic [CNT_W-1:0] count_q, outst_q, discard_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [XLEN-1:0]  fifo_q [DEPTH];

    logic hit, flush, pop, issue, push, drop;

    assign hit = (exp_addr_q == req_addr_q);

    // Core-side FSM: accept, compare against the expected sequential address, return data.
    always_comb begin
        state_d        = state_q;
        flush          = 1'b0;
        pop            = 1'b0;
        bus.c_gnt      = 1'b0;
        bus.c_data_gnt = 1'b0;
        bus.c_data     = '0;
        case (state_q)
            C_IDLE: begin
                if (bus.c_req && !arst) begin
                    bus.c_gnt = 1'b1;
                    state_d   = C_CHECK;
                end
            end
            C_CHECK: begin
                flush   = !hit;
                state_d = C_WAIT;
            end
            C_WAIT: begin
                // count_q is registered, so a push this cycle is only poppable next cycle
                if (count_q != '0) begin
                    pop            = 1'b1;
                    bus.c_data_gnt = 1'b1;
                    bus.c_data     = fifo_q[rd_ptr_q];
                    state_d        = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    // Memory-side issue: fifo entries plus in-flight reads never exceed DEPTH.
    always_comb begin
        bus.m_req  = !arst && !flush &&
                     (({1'b0, count_q} + {1'b0, outst_q}) < (CNT_W+1)'(DEPTH));
        bus.m_addr = fetch_addr_q;
        issue      = bus.m_req && bus.m_gnt;
        drop       = bus.m_valid && (discard_q != '0);
        push       = bus.m_valid && (discard_q == '0) && !flush;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= C_IDLE;
            req_addr_q   <= RESET_PC;
            exp_addr_q   <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            count_q      <= '0;
            outst_q      <= '0;
            discard_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_q + CNT_W'(issue) - CNT_W'(bus.m_valid);
            if (bus.c_gnt) begin
                req_addr_q <= bus.c_addr & ALIGN_MASK;
            end
            if (flush) begin
                // every read still in flight after this cycle belongs to the old stream
                count_q      <= '0;
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                discard_q    <= outst_q - CNT_W'(bus.m_valid);
                fetch_addr_q <= req_addr_q;
                exp_addr_q   <= req_addr_q;
            end else begin
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                    exp_addr_q <= exp_addr_q + WORD;
                end
                if (drop) begin
                    discard_q <= discard_q - CNT_W'(1);
                end
                if (issue) begin
                    fetch_addr_q <= fetch_addr_q + WORD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= bus.m_data;
        end
    end

`ifdef LADYBIRD_PREFETCH_STATS_EN
    // Saturating hit/miss counters, one event per address check.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == C_CHECK) begin
            if (hit) begin
                if (hit_count != 32'hFFFF_FFFF) begin
                    hit_count <= hit_count + 32'd1;
                end
            end else if (miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
